// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : riscv_ctrl_pkg                                     |
// | Description : Shared encodings for the multi-cycle RV32I-subset  |
// |               controller: opcodes, FSM states, mux selects,      |
// |               ALUOp codes and branch func3 codes.                |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package riscv_ctrl_pkg;

  // Supported major opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Sequencer states
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_EXEC_R  = 4'd7,
    S_EXEC_I  = 4'd8,
    S_ALU_WB  = 4'd9,
    S_BRANCH  = 4'd10,
    S_HALT    = 4'd11
  } state_e;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // AluSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // AluSrcB
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Branch func3 codes
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

endpackage
`default_nettype wire

// File: rtl/mc_branch_eval.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mc_branch_eval                                     |
// | Description : Combinational branch condition evaluator. Uses the |
// |               zero/sign flags of rs1 - rs2; unsupported func3    |
// |               codes behave as a never-taken branch (NOP).        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module mc_branch_eval
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       zero_flag,
  input  logic       sign_flag,
  output logic       taken
);

  // Decode func3 into a taken decision
  always_comb begin
    taken = 1'b0;
    case (func3)
      F3_BEQ:  taken = zero_flag;
      F3_BNE:  taken = ~zero_flag;
      F3_BLT:  taken = sign_flag;
      F3_BGE:  taken = ~sign_flag;
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : multicycle_ctrl_fsm                                |
// | Description : Multi-cycle sequencer for an RV32I-subset datapath |
// |               with a shared memory port, req/ready handshake and |
// |               wait-state timeout.                                |
// |               Optional macro MCC_PERF_CNT_EN adds cycle_cnt and  |
// |               instret_cnt performance counters.                  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
`ifdef MCC_PERF_CNT_EN
  ,
  parameter int PERF_W   = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       zero_flag,
  input  logic       sign_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] alu_op,
  output logic       illegal_instr,
  output logic       bus_err
`ifdef MCC_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instret_cnt
`endif
);

  // Timeout fires on the stalled cycle that would bring the count to WAIT_MAX
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       branch_taken;

  mc_branch_eval u_branch_eval (
    .func3     (func3),
    .zero_flag (zero_flag),
    .sign_flag (sign_flag),
    .taken     (branch_taken)
  );

  assign illegal_instr = illegal_q;
  assign bus_err       = bus_err_q;

  // Next-state, control outputs, sticky flags and wait counter
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures OldPC + B-immediate (branch target)
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_STORE) begin
          imm_src = IMM_S;
          state_d = S_MEM_WR;
        end else begin
          imm_src = IMM_I;
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = RES_RDATA;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNC;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_op    = ALUOP_FUNC;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = branch_taken;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Wait-state timeout overrides the normal stall
    if (mem_req && !mem_ready && (wait_cnt_q == WAIT_LAST)) begin
      state_d   = S_HALT;
      bus_err_d = 1'b1;
    end

    if (mem_ready || (state_d != state_q)) begin
      wait_cnt_d = 8'd0;
    end else if (mem_req) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State, wait counter and sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 8'd0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

`ifdef MCC_PERF_CNT_EN
  logic [PERF_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [PERF_W-1:0] instret_cnt_q, instret_cnt_d;
  logic              retire;

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;

  // Count active cycles and instruction retirements (wrapping)
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    retire        = (state_d == S_FETCH) &&
                    ((state_q == S_MEM_WB) || (state_q == S_MEM_WR) ||
                     (state_q == S_ALU_WB) || (state_q == S_BRANCH));
    if ((state_q != S_IDLE) && (state_q != S_HALT)) cycle_cnt_d = cycle_cnt_q + 1'b1;
    if (retire) instret_cnt_d = instret_cnt_q + 1'b1;
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_multicycle_ctrl_fsm                             |
// | Description : Self-checking bench for multicycle_ctrl_fsm with a |
// |               per-instruction reference model. Honours          |
// |               MCC_PERF_CNT_EN when defined.                      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_multicycle_ctrl_fsm;

  localparam int WAIT_MAX = 6;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic       zero_flag = 1'b0;
  logic       sign_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, alu_op;
  logic       illegal_instr, bus_err;
`ifdef MCC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl_fsm #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .func3         (func3),
    .zero_flag     (zero_flag),
    .sign_flag     (sign_flag),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .imm_src       (imm_src),
    .alu_op        (alu_op),
    .illegal_instr (illegal_instr),
    .bus_err       (bus_err)
`ifdef MCC_PERF_CNT_EN
    ,
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   m_cyc = 0;
  int   m_ret = 0;
  logic m_ill = 1'b0;
  logic m_berr = 1'b0;

  logic [17:0] obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, imm_src, alu_op, illegal_instr, bus_err};

  // ctl = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}
  function automatic logic [17:0] ev(input logic [5:0] ctl, input logic [1:0] sa, sb, rs, is, aop);
    return {ctl, sa, sb, rs, is, aop, m_ill, m_berr};
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp);
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ill = 1'b0; m_berr = 1'b0; m_cyc = 0; m_ret = 0;
    mem_ready = 1'($urandom);
    chk("reset", ev(6'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("idle", ev(6'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tick();
  endtask

  task automatic fetch(input int waits);
    for (int k = 0; k < waits; k++) begin
      mem_ready = 1'b0;
      chk("fetch_wait", ev(6'b100000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00));
      tick(); m_cyc++;
    end
    mem_ready = 1'b1;
    chk("fetch", ev(6'b100110, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00));
    tick(); m_cyc++;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z, s,
                           input int fw, dw);
    logic tk;
    opcode = op; func3 = f3; zero_flag = z; sign_flag = s;
    tk = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (f3 == 3'b100) ? s : (f3 == 3'b101) ? !s : 1'b0;
    fetch(fw);
    mem_ready = 1'($urandom);
    chk("decode", ev(6'b0, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00));
    tick(); m_cyc++;
    if (op == LW || op == SW) begin
      mem_ready = 1'($urandom);
      chk(op == LW ? "lw_adr" : "sw_adr", ev(6'b0, 2'b10, 2'b01, 2'b00, (op == SW) ? 2'b01 : 2'b00, 2'b00));
      tick(); m_cyc++;
      for (int k = 0; k <= dw; k++) begin
        mem_ready = (k == dw);
        if (op == LW) chk("lw_rd", ev(6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        else          chk("sw_wr", ev(6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tick(); m_cyc++;
      end
      if (op == LW) begin
        mem_ready = 1'($urandom);
        chk("lw_wb", ev(6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
        tick(); m_cyc++;
      end
    end else if (op == RT || op == IT) begin
      mem_ready = 1'($urandom);
      if (op == RT) chk("exec_r", ev(6'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10));
      else          chk("exec_i", ev(6'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10));
      tick(); m_cyc++;
      mem_ready = 1'($urandom);
      chk("alu_wb", ev(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      tick(); m_cyc++;
    end else begin
      mem_ready = 1'($urandom);
      chk("branch", ev({4'b0000, tk, 1'b0}, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01));
      tick(); m_cyc++;
    end
    m_ret++;
  endtask

`ifdef MCC_PERF_CNT_EN
  task automatic chk_perf(input string tag);
    checks++;
    assert (cycle_cnt === 32'(m_cyc) && instret_cnt === 32'(m_ret)) else begin
      errors++;
      $error("FAIL %s observed=%0d/%0d expected=%0d/%0d", tag, cycle_cnt, instret_cnt, m_cyc, m_ret);
    end
  endtask
`endif

  initial begin
    logic [6:0] ops [5];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BR;

    // R, I, branch from reset: 4 + 4 + 3 cycles
    do_reset();
    run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(IT, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(BR, 3'b000, 1'b1, 1'b0, 0, 0);
`ifdef MCC_PERF_CNT_EN
    chk_perf("perf_rib");
`endif

    // lw zero waits, sw with three data wait states
    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 3);

    // Branch conditions
    run_instr(BR, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(BR, 3'b001, 1'b1, 1'b0, 0, 0);
    run_instr(BR, 3'b010, 1'b1, 1'b1, 0, 0);
    run_instr(BR, 3'b100, 1'b0, 1'b1, 0, 0);
    run_instr(BR, 3'b101, 1'b0, 1'b1, 0, 0);

    // Longest legal stalls on both accesses of one instruction
    run_instr(LW, 3'b010, 1'b0, 1'b0, WAIT_MAX - 1, WAIT_MAX - 1);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      run_instr(ops[$urandom_range(0, 4)], 3'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, WAIT_MAX - 1)), int'($urandom_range(0, WAIT_MAX - 1)));
    end
`ifdef MCC_PERF_CNT_EN
    chk_perf("perf_random");
`endif

    // Illegal opcode: HALT with sticky flag until reset
    opcode = BAD;
    fetch(1);
    mem_ready = 1'($urandom);
    chk("decode_bad", ev(6'b0, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00));
    tick();
    m_ill = 1'b1;
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom);
      chk("halt_illegal", ev(6'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      tick();
    end
    do_reset();

    // Fetch timeout
    for (int k = 0; k < WAIT_MAX; k++) begin
      mem_ready = 1'b0;
      chk("timeout_wait", ev(6'b100000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00));
      tick();
    end
    m_berr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'($urandom);
      chk("timeout_halt", ev(6'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      tick();
    end
    do_reset();

    // Reset in the middle of a data read
    opcode = LW;
    fetch(0);
    mem_ready = 1'b0;
    chk("decode_lw", ev(6'b0, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00));
    tick();
    chk("lw_adr", ev(6'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00));
    tick();
    chk("lw_rd_pending", ev(6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    #1;
    do_reset();
    fetch(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
